// File: rtl/param_updown_counter.sv
// Up/down counter over 0..MAX_COUNT that wraps or saturates at the range ends.
// Define COUNTER_OVF_STICKY_EN to build the sticky range-end flag (ovf_sticky).
module param_updown_counter #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_COUNT = 255,
  parameter bit          SATURATE  = 1'b0
) (
  input  logic             clk,
  input  logic             reset_btn,
  input  logic             enable,
  input  logic             up_down,
  input  logic             preset_btn,
  input  logic [WIDTH-1:0] load_value,
  input  logic             clear_ovf,
  output logic [WIDTH-1:0] count,
  output logic             terminal_count,
  output logic             wrap_pulse,
  output logic             ovf_sticky
);

  localparam logic [WIDTH-1:0] MaxCnt = WIDTH'(MAX_COUNT);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q,  wrap_d;

  // Next-state selection; preset wins over counting, and the up-direction
  // test uses >= so the count can never escape above MAX_COUNT.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (preset_btn) begin
      count_d = (load_value > MaxCnt) ? MaxCnt : load_value;
    end else if (enable) begin
      if (up_down) begin
        if (count_q >= MaxCnt) begin
          count_d = SATURATE ? MaxCnt : '0;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end else begin
        if (count_q == '0) begin
          count_d = SATURATE ? '0 : MaxCnt;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_btn) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count          = count_q;
  assign wrap_pulse     = wrap_q;
  assign terminal_count = up_down ? (count_q == MaxCnt) : (count_q == '0);

`ifdef COUNTER_OVF_STICKY_EN
  logic ovf_q;

  // A new range-end event beats a simultaneous clear request.
  always_ff @(posedge clk) begin
    if (reset_btn) begin
      ovf_q <= 1'b0;
    end else if (wrap_d) begin
      ovf_q <= 1'b1;
    end else if (clear_ovf) begin
      ovf_q <= 1'b0;
    end
  end

  assign ovf_sticky = ovf_q;
`else
  logic unused_clear_ovf;
  assign unused_clear_ovf = clear_ovf;
  assign ovf_sticky       = 1'b0;
`endif

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench for param_updown_counter: three instances (defaults, MAX_COUNT=9
// saturating, MAX_COUNT=9 wrapping) share one set of stimulus inputs.
module tb_param_updown_counter;

`ifdef COUNTER_OVF_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic       clk;
  logic       reset_btn;
  logic       enable;
  logic       up_down;
  logic       preset_btn;
  logic [7:0] load_value;
  logic       clear_ovf;

  // Index 0 = defaults, 1 = MAX_COUNT 9 saturating, 2 = MAX_COUNT 9 wrapping
  logic [7:0] cnt  [3];
  logic       term [3];
  logic       wrap [3];
  logic       ovf  [3];

  int checks = 0;
  int errors = 0;

  param_updown_counter dutDef (
    .clk(clk), .reset_btn(reset_btn), .enable(enable), .up_down(up_down),
    .preset_btn(preset_btn), .load_value(load_value), .clear_ovf(clear_ovf),
    .count(cnt[0]), .terminal_count(term[0]), .wrap_pulse(wrap[0]), .ovf_sticky(ovf[0])
  );

  param_updown_counter #(.WIDTH(8), .MAX_COUNT(9), .SATURATE(1'b1)) dutSat (
    .clk(clk), .reset_btn(reset_btn), .enable(enable), .up_down(up_down),
    .preset_btn(preset_btn), .load_value(load_value), .clear_ovf(clear_ovf),
    .count(cnt[1]), .terminal_count(term[1]), .wrap_pulse(wrap[1]), .ovf_sticky(ovf[1])
  );

  param_updown_counter #(.WIDTH(8), .MAX_COUNT(9), .SATURATE(1'b0)) dutWrap (
    .clk(clk), .reset_btn(reset_btn), .enable(enable), .up_down(up_down),
    .preset_btn(preset_btn), .load_value(load_value), .clear_ovf(clear_ovf),
    .count(cnt[2]), .terminal_count(term[2]), .wrap_pulse(wrap[2]), .ovf_sticky(ovf[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle so outputs are sampled away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_btn  = 1'b1;
    enable     = 1'b1;
    preset_btn = 1'b1;
    up_down    = 1'b1;
    load_value = 8'h33;
    clear_ovf  = 1'b0;
    step();
    step();
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (cnt[d] !== 8'd0) begin
        errors++;
        $display("[TB] FAIL reset_count dut%0d: got %0d expected 0", d, cnt[d]);
      end
      checks++;
      if (wrap[d] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_wrap dut%0d: got %b expected 0", d, wrap[d]);
      end
      checks++;
      if (ovf[d] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_ovf dut%0d: got %b expected 0", d, ovf[d]);
      end
    end
    reset_btn  = 1'b0;
    preset_btn = 1'b0;
    enable     = 1'b0;
  endtask

  task automatic test_count_up_default();
    logic [7:0] expCnt;
    reset_btn = 1'b1;
    step();
    step();
    reset_btn = 1'b0;
    enable    = 1'b1;
    up_down   = 1'b1;
    checks++;
    if (term[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL up_term_start: got %b expected 0", term[0]);
    end
    for (int e = 1; e <= 256; e++) begin
      step();
      expCnt = 8'(e % 256);
      checks++;
      if (cnt[0] !== expCnt) begin
        errors++;
        $display("[TB] FAIL up_count edge%0d: got %0d expected %0d", e, cnt[0], expCnt);
      end
      checks++;
      if (wrap[0] !== (e == 256)) begin
        errors++;
        $display("[TB] FAIL up_wrap edge%0d: got %b expected %b", e, wrap[0], (e == 256));
      end
      checks++;
      if (term[0] !== (expCnt == 8'd255)) begin
        errors++;
        $display("[TB] FAIL up_term edge%0d: got %b expected %b", e, term[0], (expCnt == 8'd255));
      end
    end
    checks++;
    if (ovf[0] !== STICKY) begin
      errors++;
      $display("[TB] FAIL up_ovf: got %b expected %b", ovf[0], STICKY);
    end
    enable = 1'b0;
  endtask

  task automatic test_saturate();
    logic [7:0] expSat;
    logic [7:0] expWrp;
    reset_btn = 1'b1;
    step();
    reset_btn = 1'b0;
    enable    = 1'b1;
    up_down   = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      step();
      expSat = (e < 9) ? 8'(e) : 8'd9;
      expWrp = 8'(e % 10);
      checks++;
      if (cnt[1] !== expSat) begin
        errors++;
        $display("[TB] FAIL sat_count edge%0d: got %0d expected %0d", e, cnt[1], expSat);
      end
      checks++;
      if (wrap[1] !== (e >= 10)) begin
        errors++;
        $display("[TB] FAIL sat_wrap edge%0d: got %b expected %b", e, wrap[1], (e >= 10));
      end
      checks++;
      if (cnt[2] !== expWrp) begin
        errors++;
        $display("[TB] FAIL wrp_count edge%0d: got %0d expected %0d", e, cnt[2], expWrp);
      end
      checks++;
      if (wrap[2] !== (e == 10)) begin
        errors++;
        $display("[TB] FAIL wrp_wrap edge%0d: got %b expected %b", e, wrap[2], (e == 10));
      end
    end
    up_down = 1'b0;
    step();
    checks++;
    if (cnt[1] !== 8'd8 || wrap[1] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sat_turn_down: got count %0d wrap %b expected count 8 wrap 0", cnt[1], wrap[1]);
    end
    checks++;
    if (term[1] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sat_turn_term: got %b expected 0", term[1]);
    end
    checks++;
    if (cnt[2] !== 8'd1 || wrap[2] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wrp_turn_down: got count %0d wrap %b expected count 1 wrap 0", cnt[2], wrap[2]);
    end
    enable = 1'b0;
  endtask

  task automatic test_wrap_down_and_clamp();
    reset_btn = 1'b1;
    step();
    reset_btn = 1'b0;
    enable    = 1'b1;
    up_down   = 1'b0;
    step();
    checks++;
    if (cnt[2] !== 8'd9 || wrap[2] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wrp_down: got count %0d wrap %b expected count 9 wrap 1", cnt[2], wrap[2]);
    end
    checks++;
    if (cnt[1] !== 8'd0 || wrap[1] !== 1'b1 || term[1] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL sat_down: got count %0d wrap %b term %b expected 0 1 1", cnt[1], wrap[1], term[1]);
    end
    checks++;
    if (cnt[0] !== 8'd255 || wrap[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL def_down: got count %0d wrap %b expected count 255 wrap 1", cnt[0], wrap[0]);
    end
    enable     = 1'b0;
    preset_btn = 1'b1;
    load_value = 8'hAA;
    step();
    checks++;
    if (cnt[0] !== 8'hAA || cnt[1] !== 8'd9 || cnt[2] !== 8'd9) begin
      errors++;
      $display("[TB] FAIL preset_clamp: got %0d %0d %0d expected 170 9 9", cnt[0], cnt[1], cnt[2]);
    end
    checks++;
    if (wrap[0] !== 1'b0 || wrap[1] !== 1'b0 || wrap[2] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL preset_wrap: got %b %b %b expected 0 0 0", wrap[0], wrap[1], wrap[2]);
    end
    load_value = 8'd5;
    step();
    checks++;
    if (cnt[0] !== 8'd5 || cnt[1] !== 8'd5 || cnt[2] !== 8'd5) begin
      errors++;
      $display("[TB] FAIL preset_load5: got %0d %0d %0d expected 5 5 5", cnt[0], cnt[1], cnt[2]);
    end
    preset_btn = 1'b0;
  endtask

  task automatic test_priority();
    preset_btn = 1'b1;
    enable     = 1'b1;
    up_down    = 1'b1;
    load_value = 8'h10;
    step();
    checks++;
    if (cnt[0] !== 8'h10 || cnt[2] !== 8'd9) begin
      errors++;
      $display("[TB] FAIL preset_over_enable: got %0d %0d expected 16 9", cnt[0], cnt[2]);
    end
    reset_btn = 1'b1;
    step();
    checks++;
    if (cnt[0] !== 8'd0 || cnt[1] !== 8'd0 || cnt[2] !== 8'd0) begin
      errors++;
      $display("[TB] FAIL reset_over_preset: got %0d %0d %0d expected 0 0 0", cnt[0], cnt[1], cnt[2]);
    end
    reset_btn  = 1'b0;
    preset_btn = 1'b0;
    enable     = 1'b0;
  endtask

  task automatic test_hold_and_direction();
    preset_btn = 1'b1;
    load_value = 8'd3;
    step();
    preset_btn = 1'b0;
    enable     = 1'b0;
    step();
    step();
    checks++;
    if (cnt[0] !== 8'd3 || cnt[1] !== 8'd3 || wrap[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL hold: got count %0d %0d wrap %b expected 3 3 0", cnt[0], cnt[1], wrap[0]);
    end
    enable  = 1'b1;
    up_down = 1'b1;
    step();
    checks++;
    if (cnt[2] !== 8'd4) begin
      errors++;
      $display("[TB] FAIL dir_up: got %0d expected 4", cnt[2]);
    end
    up_down = 1'b0;
    step();
    checks++;
    if (cnt[2] !== 8'd3) begin
      errors++;
      $display("[TB] FAIL dir_down_same_edge: got %0d expected 3", cnt[2]);
    end
    enable = 1'b0;
  endtask

  task automatic test_sticky();
    reset_btn = 1'b1;
    step();
    reset_btn  = 1'b0;
    preset_btn = 1'b1;
    load_value = 8'd9;
    step();
    preset_btn = 1'b0;
    enable     = 1'b1;
    up_down    = 1'b1;
    step();
    checks++;
    if (cnt[2] !== 8'd0 || wrap[2] !== 1'b1 || ovf[2] !== STICKY) begin
      errors++;
      $display("[TB] FAIL sticky_set: got count %0d wrap %b ovf %b expected 0 1 %b", cnt[2], wrap[2], ovf[2], STICKY);
    end
    checks++;
    if (ovf[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sticky_def_clear: got %b expected 0", ovf[0]);
    end
    enable = 1'b0;
    step();
    checks++;
    if (ovf[2] !== STICKY || wrap[2] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sticky_hold: got ovf %b wrap %b expected %b 0", ovf[2], wrap[2], STICKY);
    end
    preset_btn = 1'b1;
    step();
    preset_btn = 1'b0;
    enable     = 1'b1;
    clear_ovf  = 1'b1;
    step();
    checks++;
    if (ovf[2] !== STICKY || wrap[2] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL sticky_set_beats_clear: got ovf %b wrap %b expected %b 1", ovf[2], wrap[2], STICKY);
    end
    enable = 1'b0;
    step();
    checks++;
    if (ovf[2] !== 1'b0 || ovf[1] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sticky_clear: got %b %b expected 0 0", ovf[2], ovf[1]);
    end
    clear_ovf = 1'b0;
  endtask

  initial begin
    reset_btn  = 1'b1;
    enable     = 1'b0;
    up_down    = 1'b1;
    preset_btn = 1'b0;
    load_value = 8'd0;
    clear_ovf  = 1'b0;
    test_reset();
    test_count_up_default();
    test_saturate();
    test_wrap_down_and_clamp();
    test_priority();
    test_hold_and_direction();
    test_sticky();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
